bdd_tree_engine: RTL and testbench

Parametrised decision-tree/BDD traversal engine; the next generation of the single-tree classifier.
- Accepts a feature vector plus a root address and walks a tree held in an external synchronous node RAM.
- At each internal node it forms a signed dot product of features and node coefficients, compares it to the node threshold, and follows one of two child pointers until it reaches a leaf, which carries the class.
- Multiple trees share one node RAM, selected by root address; sits between the feature front-end and the vote/aggregation logic.

---
 rtl/bdd_pkg.sv | 39 +++
 rtl/bdd_tree_engine_if.sv | 40 ++++
 rtl/bdd_node_mac.sv | 111 +++++++++++
 rtl/bdd_tree_engine.sv | 145 ++++++++++++++
 tb/tb_bdd_tree_engine.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bdd_pkg.sv
// bdd_pkg: shared FSM state type and node-word field layout helpers for the BDD tree engine.
package bdd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      LAT,
      MAC,
      CMP,
      DONE
   } state_e;

   function automatic int acc_width(int num_feat, int feat_w, int coef_w);
      return feat_w + coef_w + 1 + $clog2(num_feat);
   endfunction

   // Node word, LSB first: coef[0..NUM_FEAT-1], threshold, lo_child, hi_child.
   function automatic int thr_lsb(int num_feat, int coef_w);
      return num_feat * coef_w;
   endfunction

   function automatic int lo_lsb(int num_feat, int coef_w, int acc_w);
      return thr_lsb(num_feat, coef_w) + acc_w;
   endfunction

   function automatic int hi_lsb(int num_feat, int coef_w, int acc_w, int addr_w);
      return lo_lsb(num_feat, coef_w, acc_w) + addr_w + 1;
   endfunction

   function automatic int node_w(int num_feat, int coef_w, int acc_w, int addr_w);
      return hi_lsb(num_feat, coef_w, acc_w, addr_w) + addr_w + 1;
   endfunction

   // The bit just above the address field marks a child pointer as a leaf.
   function automatic logic is_leaf(logic [31:0] child, int addr_w);
      return child[addr_w];
   endfunction

endpackage

// File: rtl/bdd_tree_engine_if.sv
// bdd_tree_engine_if: request, node-RAM and result signals of the tree engine.
interface bdd_tree_engine_if
   import bdd_pkg::*;
#(
   parameter int NUM_FEAT  = 5,
   parameter int FEAT_W    = 8,
   parameter int COEF_W    = 8,
   parameter int ADDR_W    = 11,
   parameter int CLASS_W   = 8,
   parameter int MAX_DEPTH = 32,
   parameter int ACC_W     = FEAT_W + COEF_W + 1 + $clog2(NUM_FEAT)
) ();

   localparam int NODE_W  = node_w(NUM_FEAT, COEF_W, ACC_W, ADDR_W);
   localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

   logic                         in_valid;
   logic                         in_ready;
   logic [NUM_FEAT*FEAT_W-1:0]   in_feat;
   logic [ADDR_W-1:0]            in_root;
   logic                         node_rd_en;
   logic [ADDR_W-1:0]            node_addr;
   logic [NODE_W-1:0]            node_data;
   logic                         out_valid;
   logic                         out_ready;
   logic [CLASS_W-1:0]           out_class;
   logic                         out_err;
   logic [DEPTH_W-1:0]           out_depth;

   modport slave (
      input  in_valid, in_feat, in_root, node_data, out_ready,
      output in_ready, node_rd_en, node_addr, out_valid, out_class, out_err, out_depth
   );

   modport master (
      output in_valid, in_feat, in_root, node_data, out_ready,
      input  in_ready, node_rd_en, node_addr, out_valid, out_class, out_err, out_depth
   );

endinterface

// File: rtl/bdd_node_mac.sv
// bdd_node_mac: signed dot product of unsigned features and signed coefficients.
// Define BDD_PARALLEL_MAC_EN for a one-cycle adder tree; default is one product per cycle.
module bdd_node_mac #(
   parameter int NUM_FEAT = 5,
   parameter int FEAT_W   = 8,
   parameter int COEF_W   = 8,
   parameter int ACC_W    = FEAT_W + COEF_W + 1 + $clog2(NUM_FEAT)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NUM_FEAT*FEAT_W-1:0]  feat,
   input  logic [NUM_FEAT*COEF_W-1:0]  coef,
   output logic signed [ACC_W-1:0]     acc,
   output logic                        done
);

   localparam int PROD_W = FEAT_W + COEF_W + 1;

   logic signed [ACC_W-1:0] prod_ext [NUM_FEAT];

   // Features are zero-extended so the product is a true unsigned-by-signed multiply.
   for (genvar i = 0; i < NUM_FEAT; i++) begin : g_prod
      logic signed [PROD_W-1:0] f_ext;
      logic signed [PROD_W-1:0] c_ext;
      logic signed [PROD_W-1:0] p;
      assign f_ext       = PROD_W'({1'b0, feat[i*FEAT_W +: FEAT_W]});
      assign c_ext       = PROD_W'($signed(coef[i*COEF_W +: COEF_W]));
      assign p           = f_ext * c_ext;
      assign prod_ext[i] = ACC_W'(p);
   end

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    busy_q, busy_d;

`ifdef BDD_PARALLEL_MAC_EN
   logic signed [ACC_W-1:0] sum;

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_FEAT; i++) begin
         sum = sum + prod_ext[i];
      end
   end

   always_comb begin
      acc_d  = acc_q;
      busy_d = busy_q;
      if (start) begin
         acc_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         acc_d  = sum;
         busy_d = 1'b0;
      end
   end

   assign done = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         busy_q <= busy_d;
      end
   end
`else
   localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

   logic [IDX_W-1:0] idx_q, idx_d;

   always_comb begin
      acc_d  = acc_q;
      busy_d = busy_q;
      idx_d  = idx_q;
      if (start) begin
         acc_d  = '0;
         busy_d = 1'b1;
         idx_d  = '0;
      end else if (busy_q) begin
         acc_d = acc_q + prod_ext[idx_q];
         if (idx_q == LAST_IDX) begin
            busy_d = 1'b0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   // Done flags the cycle whose product is the last one, so the sum is ready one edge later.
   assign done = busy_q && (idx_q == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         busy_q <= 1'b0;
         idx_q  <= '0;
      end else begin
         acc_q  <= acc_d;
         busy_q <= busy_d;
         idx_q  <= idx_d;
      end
   end
`endif

   assign acc = acc_q;

endmodule

// File: rtl/bdd_tree_engine.sv
// bdd_tree_engine: walks a decision tree held in external node RAM and reports the leaf class.
// Per-node MAC latency depends on BDD_PARALLEL_MAC_EN inside bdd_node_mac.
module bdd_tree_engine
   import bdd_pkg::*;
#(
   parameter int NUM_FEAT  = 5,
   parameter int FEAT_W    = 8,
   parameter int COEF_W    = 8,
   parameter int ADDR_W    = 11,
   parameter int CLASS_W   = 8,
   parameter int MAX_DEPTH = 32,
   parameter int ACC_W     = FEAT_W + COEF_W + 1 + $clog2(NUM_FEAT)
) (
   input  logic                clk,
   input  logic                rst,
   bdd_tree_engine_if.slave    bus
);

   localparam int NODE_W  = node_w(NUM_FEAT, COEF_W, ACC_W, ADDR_W);
   localparam int THR_LSB = thr_lsb(NUM_FEAT, COEF_W);
   localparam int LO_LSB  = lo_lsb(NUM_FEAT, COEF_W, ACC_W);
   localparam int HI_LSB  = hi_lsb(NUM_FEAT, COEF_W, ACC_W, ADDR_W);
   localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

   state_e                      state_q, state_d;
   logic [NUM_FEAT*FEAT_W-1:0]  feat_q, feat_d;
   logic [ADDR_W-1:0]           cur_q, cur_d;
   logic [NODE_W-1:0]           node_q, node_d;
   logic [DEPTH_W-1:0]          depth_q, depth_d;
   logic [CLASS_W-1:0]          class_q, class_d;
   logic                        err_q, err_d;
   logic                        out_valid_q, out_valid_d;
   logic                        mac_start;
   logic                        mac_done;
   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_W-1:0]     thr;
   logic [ADDR_W:0]             chosen;

   bdd_node_mac #(
      .NUM_FEAT (NUM_FEAT),
      .FEAT_W   (FEAT_W),
      .COEF_W   (COEF_W),
      .ACC_W    (ACC_W)
   ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .start (mac_start),
      .feat  (feat_q),
      .coef  (node_q[NUM_FEAT*COEF_W-1:0]),
      .acc   (acc),
      .done  (mac_done)
   );

   // Ties go to the low child.
   assign thr    = node_q[THR_LSB +: ACC_W];
   assign chosen = (acc > thr) ? node_q[HI_LSB +: ADDR_W+1] : node_q[LO_LSB +: ADDR_W+1];

   always_comb begin
      state_d     = state_q;
      feat_d      = feat_q;
      cur_d       = cur_q;
      node_d      = node_q;
      depth_d     = depth_q;
      class_d     = class_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      mac_start   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               feat_d  = bus.in_feat;
               cur_d   = bus.in_root;
               depth_d = '0;
               state_d = RD;
            end
         end
         RD:  state_d = LAT;
         LAT: begin
            node_d    = bus.node_data;
            mac_start = 1'b1;
            state_d   = MAC;
         end
         MAC: begin
            if (mac_done) begin
               state_d = CMP;
            end
         end
         CMP: begin
            depth_d = depth_q + DEPTH_W'(1);
            if (is_leaf(32'(chosen), ADDR_W)) begin
               class_d = chosen[CLASS_W-1:0];
               err_d   = 1'b0;
               state_d = DONE;
            end else if (depth_d == DEPTH_W'(MAX_DEPTH)) begin
               class_d = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cur_d   = chosen[ADDR_W-1:0];
               state_d = RD;
            end
         end
         DONE: begin
            // Result is presented from a register one cycle after entering DONE.
            out_valid_d = 1'b1;
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         feat_q      <= '0;
         cur_q       <= '0;
         node_q      <= '0;
         depth_q     <= '0;
         class_q     <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         feat_q      <= feat_d;
         cur_q       <= cur_d;
         node_q      <= node_d;
         depth_q     <= depth_d;
         class_q     <= class_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.node_rd_en = (state_q == RD);
   assign bus.node_addr  = cur_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_class  = class_q;
   assign bus.out_err    = err_q;
   assign bus.out_depth  = depth_q;

endmodule

// File: tb/tb_bdd_tree_engine.sv
// tb_bdd_tree_engine: directed vectors with a scoreboard queue and a decoupled result monitor.
module tb_bdd_tree_engine;

`ifdef BDD_PARALLEL_MAC_EN
   localparam int NODE_LAT = 4;
`else
   localparam int NODE_LAT = 8;
`endif

   typedef struct {
      logic [7:0] cls;
      logic       err;
      logic [5:0] depth;
      int         lat;
      time        t_acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;
   time  t_rise = 0;
   logic valid_prev = 1'b0;
   logic [83:0] mem [16];

   always #5 clk = ~clk;

   bdd_tree_engine_if #(
      .NUM_FEAT(5), .FEAT_W(8), .COEF_W(8), .ADDR_W(11),
      .CLASS_W(8), .MAX_DEPTH(32), .ACC_W(20)
   ) bus ();

   bdd_tree_engine #(
      .NUM_FEAT(5), .FEAT_W(8), .COEF_W(8), .ADDR_W(11),
      .CLASS_W(8), .MAX_DEPTH(32), .ACC_W(20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Synchronous node RAM: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (bus.node_rd_en) bus.node_data <= mem[bus.node_addr[3:0]];
   end

   function automatic logic [11:0] leaf(input logic [7:0] cls);
      return {1'b1, 3'b000, cls};
   endfunction

   function automatic logic [11:0] ptr(input logic [10:0] a);
      return {1'b0, a};
   endfunction

   function automatic logic [83:0] mk_node(input logic [39:0] coefs, input logic [19:0] thr,
                                           input logic [11:0] lo, input logic [11:0] hi);
      return {hi, lo, thr, coefs};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [39:0] feat, input logic [10:0] root, input bit push,
                                input logic [7:0] cls, input logic err, input logic [5:0] depth,
                                input int lat);
      int n = 0;
      exp_t e;
      @(negedge clk);
      while (!bus.in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_feat  = feat;
      bus.in_root  = root;
      @(posedge clk);
      if (push) begin
         e.cls = cls; e.err = err; e.depth = depth; e.lat = lat; e.t_acc = $time;
         sb.push_back(e);
      end
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic waitDrain(input int limit);
      int n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", 32'(sb.size()), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops one expectation per accepted result; any result with nothing pending is an error.
   always @(negedge clk) begin
      if (bus.out_valid && !valid_prev) t_rise = $time - 5;
      valid_prev = bus.out_valid;
      if (bus.out_valid && sb.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpected_valid: got out_valid=1 required no result pending");
      end else if (bus.out_valid && bus.out_ready) begin
         mon_e = sb.pop_front();
         checkOutput("out_class", 32'(bus.out_class), 32'(mon_e.cls));
         checkOutput("out_err",   32'(bus.out_err),   32'(mon_e.err));
         checkOutput("out_depth", 32'(bus.out_depth), 32'(mon_e.depth));
         checkOutput("latency",   32'((t_rise - mon_e.t_acc) / 10), 32'(mon_e.lat));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int seen;
      int n;
      mem[0] = mk_node({5{8'sd2}}, 20'sd9, leaf(8'h15), leaf(8'h2A));
      mem[1] = mk_node({5{8'sd2}}, 20'sd10, leaf(8'h15), leaf(8'h2A));
      mem[2] = mk_node({5{8'h80}}, 20'sd0, leaf(8'h33), leaf(8'h44));
      mem[3] = mk_node({5{8'h00}}, 20'sd0, ptr(11'd3), ptr(11'd3));
      mem[4] = mk_node({5{8'h80}}, -20'sd163201, leaf(8'h33), leaf(8'h44));
      mem[5] = mk_node({5{8'sd1}}, 20'sd0, leaf(8'h01), ptr(11'd6));
      mem[6] = mk_node({5{8'sd1}}, 20'sd5, leaf(8'h66), leaf(8'h77));
      mem[7] = mk_node({8'h03, 8'hFE, 8'h02, 8'hFF, 8'h01}, 20'sd119, leaf(8'h71), leaf(8'h70));
      for (int i = 8; i < 16; i++) mem[i] = '0;

      bus.in_valid  = 1'b0;
      bus.in_feat   = '0;
      bus.in_root   = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state",
                  32'({bus.in_ready, bus.out_valid, bus.node_rd_en, bus.node_addr,
                       bus.out_class, bus.out_err, bus.out_depth}),
                  32'({1'b1, 1'b0, 1'b0, 11'd0, 8'd0, 1'b0, 6'd0}));
      rst = 1'b0;

      $display("[TB] single node, acc 10 > thr 9");
      applyStimulus({5{8'd1}}, 11'd0, 1'b1, 8'h2A, 1'b0, 6'd1, NODE_LAT + 1);
      waitDrain(100);
      $display("[TB] single node, acc equals thr");
      applyStimulus({5{8'd1}}, 11'd1, 1'b1, 8'h15, 1'b0, 6'd1, NODE_LAT + 1);
      waitDrain(100);
      $display("[TB] negative coefficients, acc -163200");
      applyStimulus({5{8'd255}}, 11'd2, 1'b1, 8'h33, 1'b0, 6'd1, NODE_LAT + 1);
      waitDrain(100);
      applyStimulus({5{8'd255}}, 11'd4, 1'b1, 8'h44, 1'b0, 6'd1, NODE_LAT + 1);
      waitDrain(100);
      $display("[TB] mixed coefficients, acc 120");
      applyStimulus({8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 11'd7, 1'b1, 8'h70, 1'b0, 6'd1, NODE_LAT + 1);
      waitDrain(100);
      $display("[TB] two-level walk");
      applyStimulus({5{8'd1}}, 11'd5, 1'b1, 8'h66, 1'b0, 6'd2, 2 * NODE_LAT + 1);
      waitDrain(100);
      $display("[TB] self-loop depth abort");
      applyStimulus({5{8'd7}}, 11'd3, 1'b1, 8'h00, 1'b1, 6'd32, 32 * NODE_LAT + 1);
      waitDrain(600);

      $display("[TB] back-pressure hold");
      bus.out_ready = 1'b0;
      applyStimulus({5{8'd1}}, 11'd0, 1'b1, 8'h2A, 1'b0, 6'd1, NODE_LAT + 1);
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 20; i++) begin
         checkOutput("hold_stable",
                     32'({bus.out_valid, bus.in_ready, bus.out_class, bus.out_err, bus.out_depth}),
                     32'({1'b1, 1'b0, 8'h2A, 1'b0, 6'd1}));
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("in_ready_after_accept", 32'({bus.in_ready, bus.out_valid}), 32'({1'b1, 1'b0}));
      waitDrain(10);

      $display("[TB] reset during second node MAC");
      applyStimulus({5{8'd1}}, 11'd5, 1'b0, 8'h00, 1'b0, 6'd0, 0);
      seen = 0;
      n = 0;
      while (seen < 2 && n < 100) begin
         @(negedge clk);
         if (bus.node_rd_en) seen++;
         n++;
      end
      checkOutput("second_read_seen", 32'(seen), 32'd2);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid_walk_reset",
                  32'({bus.in_ready, bus.out_valid, bus.node_rd_en, bus.node_addr,
                       bus.out_class, bus.out_err, bus.out_depth}),
                  32'({1'b1, 1'b0, 1'b0, 11'd0, 8'd0, 1'b0, 6'd0}));
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("no_valid_after_reset", 32'(bus.out_valid), 32'd0);
      end
      applyStimulus({5{8'd1}}, 11'd0, 1'b1, 8'h2A, 1'b0, 6'd1, NODE_LAT + 1);
      waitDrain(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
